// File: rtl/mag_hard_iron_cal.sv
// mag_hard_iron_cal -- per-axis min/max sweep for hard-iron offsets, with offset-corrected output path.
// Rev 1.0
`default_nettype none

module mag_hard_iron_cal #(
   parameter int unsigned MIN_SAMPLES = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic signed [15:0] in_x,
   input  logic signed [15:0] in_y,
   input  logic signed [15:0] in_z,
   input  logic               cal_en,
   input  logic               cal_clear,
   output logic               out_valid,
   output logic signed [15:0] out_x,
   output logic signed [15:0] out_y,
   output logic signed [15:0] out_z,
   output logic signed [15:0] off_x,
   output logic signed [15:0] off_y,
   output logic signed [15:0] off_z,
   output logic               cal_active,
   output logic               cal_done,
   output logic               cal_fail,
   output logic [7:0]         sample_cnt
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_CAL    = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   localparam logic signed [15:0] POS_MAX = 16'sh7FFF;
   localparam logic signed [15:0] NEG_MIN = 16'sh8000;
   localparam logic [7:0]         MIN_CNT = MIN_SAMPLES[7:0];

   state_t             state;
   logic signed [15:0] smp     [3];
   logic signed [15:0] min_trk [3];
   logic signed [15:0] max_trk [3];
   logic signed [15:0] off_r   [3];
   logic signed [15:0] out_r   [3];
   logic [7:0]         cnt;
   logic               done_r;
   logic               fail_r;
   logic               vld_r;

   assign smp[0] = in_x;
   assign smp[1] = in_y;
   assign smp[2] = in_z;

   function automatic logic signed [15:0] sat_sub(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
      logic signed [16:0] d;
      d = {a[15], a} - {b[15], b};
      if (d > 17'sd32767)
         sat_sub = POS_MAX;
      else if (d < -17'sd32768)
         sat_sub = NEG_MIN;
      else
         sat_sub = d[15:0];
   endfunction

   // Midpoint in 17 bits, arithmetic shift; result always fits in 16 bits.
   function automatic logic signed [15:0] midpoint(input logic signed [15:0] lo,
                                                   input logic signed [15:0] hi);
      logic signed [16:0] s;
      s = {lo[15], lo} + {hi[15], hi};
      midpoint = s[16:1];
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_RUN;
         cnt    <= 8'd0;
         done_r <= 1'b0;
         fail_r <= 1'b0;
         vld_r  <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            min_trk[i] <= POS_MAX;
            max_trk[i] <= NEG_MIN;
            off_r[i]   <= 16'sd0;
            out_r[i]   <= 16'sd0;
         end
      end else begin
         done_r <= 1'b0;
         fail_r <= 1'b0;
         vld_r  <= in_valid;

         // Output path always uses the offsets held before this edge.
         if (in_valid) begin
            for (int i = 0; i < 3; i++)
               out_r[i] <= sat_sub(smp[i], off_r[i]);
         end

         if (cal_clear) begin
            state <= S_RUN;
            cnt   <= 8'd0;
            for (int i = 0; i < 3; i++) begin
               min_trk[i] <= POS_MAX;
               max_trk[i] <= NEG_MIN;
               off_r[i]   <= 16'sd0;
            end
         end else begin
            case (state)
               S_RUN: begin
                  if (cal_en) begin
                     state <= S_CAL;
                     if (in_valid) begin
                        cnt <= 8'd1;
                        for (int i = 0; i < 3; i++) begin
                           min_trk[i] <= smp[i];
                           max_trk[i] <= smp[i];
                        end
                     end else begin
                        cnt <= 8'd0;
                        for (int i = 0; i < 3; i++) begin
                           min_trk[i] <= POS_MAX;
                           max_trk[i] <= NEG_MIN;
                        end
                     end
                  end
               end
               S_CAL: begin
                  if (in_valid) begin
                     if (cnt != 8'hFF)
                        cnt <= cnt + 8'd1;
                     for (int i = 0; i < 3; i++) begin
                        if (smp[i] < min_trk[i])
                           min_trk[i] <= smp[i];
                        if (smp[i] > max_trk[i])
                           max_trk[i] <= smp[i];
                     end
                  end
                  if (!cal_en)
                     state <= S_COMMIT;
               end
               S_COMMIT: begin
                  state <= S_RUN;
                  if (cnt >= MIN_CNT) begin
                     done_r <= 1'b1;
                     for (int i = 0; i < 3; i++)
                        off_r[i] <= midpoint(min_trk[i], max_trk[i]);
                  end else begin
                     fail_r <= 1'b1;
                  end
               end
               default: state <= S_RUN;
            endcase
         end
      end
   end

   assign out_valid  = vld_r;
   assign out_x      = out_r[0];
   assign out_y      = out_r[1];
   assign out_z      = out_r[2];
   assign off_x      = off_r[0];
   assign off_y      = off_r[1];
   assign off_z      = off_r[2];
   assign cal_active = (state == S_CAL);
   assign cal_done   = done_r;
   assign cal_fail   = fail_r;
   assign sample_cnt = cnt;

endmodule

`default_nettype wire

// File: doc/mag_hard_iron_cal.md
MAG_HARD_IRON_CAL -- requirements
Module: mag_hard_iron_cal

Interface
REQ-001 Parameter MIN_SAMPLES, default 16, SHALL set the minimum calibration samples for a commit to succeed (range 1..255).
REQ-002 clk  in  1  system clock (100 MHz); all logic SHALL be clocked on its rising edge.
REQ-003 rst  in  1  SHALL be asynchronous and active-low (0 = reset).
REQ-004 in_valid  in  1  SHALL be a one-cycle pulse marking a new sample (driven by magnetometer driver data_valid).
REQ-005 in_x, in_y, in_z  in  16 each, signed  SHALL be raw field samples, sampled only when in_valid=1.
REQ-006 cal_en  in  1  SHALL be a level; high = calibration sweep in progress.
REQ-007 cal_clear  in  1  SHALL be a one-cycle pulse that discards calibration state.
REQ-008 out_valid  out  1  SHALL be a one-cycle pulse marking corrected output.
REQ-009 out_x, out_y, out_z  out  16 each, signed  SHALL be offset-corrected samples.
REQ-010 off_x, off_y, off_z  out  16 each, signed  SHALL be the offsets currently applied.
REQ-011 cal_active  out  1  SHALL be high while in state S_CAL.
REQ-012 cal_done  out  1  SHALL pulse one cycle when a commit succeeds; cal_fail  out  1  SHALL pulse one cycle when a commit fails.
REQ-013 sample_cnt  out  8  SHALL be the calibration sample count, saturating at 255.

Function
REQ-014 FSM SHALL have states S_RUN, S_CAL, S_COMMIT; transitions: S_RUN->S_CAL when cal_en=1; S_CAL->S_COMMIT when cal_en=0; S_COMMIT->S_RUN unconditionally after one cycle.
REQ-015 On S_RUN->S_CAL, per-axis min trackers SHALL load +32767, max trackers -32768, and sample_cnt SHALL load 0.
REQ-016 In S_CAL, each in_valid SHALL update min=min(min,in), max=max(max,in) per axis (signed compare) and increment sample_cnt, saturating at 255.
REQ-017 An in_valid arriving in the same cycle as the S_RUN->S_CAL transition SHALL be counted and tracked as the first calibration sample.
REQ-018 In S_COMMIT, if sample_cnt >= MIN_SAMPLES, off_* SHALL load (max+min)>>>1 computed in 17 bits, arithmetic shift, truncated to 16 bits, and cal_done SHALL pulse; otherwise off_* SHALL be unchanged and cal_fail SHALL pulse.
REQ-019 New offsets SHALL take effect on the cycle after S_COMMIT; in_valid during S_COMMIT SHALL use the old offsets and SHALL NOT update trackers.
REQ-020 In every state, each in_valid SHALL produce out_valid exactly one cycle later (latency 1, no drops, no backpressure).
REQ-021 out_* SHALL be in_* minus off_* computed in 17 bits, saturated to [-32768, +32767]; out_* SHALL hold their value between pulses.
REQ-022 cal_clear SHALL have priority over all other events: off_*=0, trackers reset per REQ-015, sample_cnt=0, state=S_RUN, no cal_done/cal_fail pulse; a sample accepted in the same cycle SHALL be output with the pre-clear offsets.
REQ-023 If cal_en is still high after cal_clear, S_CAL SHALL be re-entered on the following cycle per REQ-014.
REQ-024 sample_cnt SHALL hold its final value in S_RUN until the next calibration entry or cal_clear.

Reset
REQ-025 While rst=0: state=S_RUN, off_*=0, out_*=0, out_valid=0, cal_active=0, cal_done=0, cal_fail=0, sample_cnt=0, min trackers +32767, max trackers -32768.
REQ-026 Reset asserted mid-calibration SHALL abandon the sweep with no commit and no pulses; operation SHALL resume in S_RUN on the first clock edge after release.

Verification
REQ-027 Pass-through: reset, in_x=100, in_y=-200, in_z=0 pulse -> out_valid next cycle, out=(100,-200,0), off=(0,0,0).
REQ-028 Calibration: cal_en=1, 16 samples with x alternating 300/-100, y 50/50, z -400/200, cal_en=0 -> cal_done pulse, off=(100,50,-100); next in (100,50,-100) -> out (0,0,0).
REQ-029 Insufficient samples: prior off_x=100, sweep of 15 samples -> cal_fail pulse, off_x remains 100, sample_cnt=15.
REQ-030 Saturation: off_x=+1000 (sweep with x = 500/1500), in_x=-32768 -> out_x=-32768; off_x=-1000, in_x=32767 -> out_x=32767.
REQ-031 Simultaneous events: cal_clear with in_valid during S_CAL -> out uses old offsets, off becomes 0, no cal_done/cal_fail; cal_clear with cal_en held high -> cal_active reasserts one cycle later.
REQ-032 Reset mid-sweep: rst=0 after 10 calibration samples -> off=0, sample_cnt=0, no cal_done/cal_fail pulse after release.
